// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: captures data_ready strobes, presents a
// first-word fall-through valid/ready stream, and tracks overflow drops.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  ovf_clear
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic push, pop, drop;

  // The extra pointer MSB distinguishes a full buffer from an empty one.
  assign level       = wr_ptr_q - rd_ptr_q;
  assign empty       = (level == '0);
  assign full        = (level == PW'(DEPTH));
  assign almost_full = (level >= PW'(AF_LEVEL));
  assign m_valid     = ~empty;
  assign m_data      = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign overflow    = overflow_q;
  assign drop_count  = drop_cnt_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign pop  = m_valid & m_ready;
  assign push = rx_valid & (~full | pop);
  assign drop = rx_valid & full & ~pop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (drop) begin
      // A drop coincident with a clear restarts the count at one.
      overflow_d = 1'b1;
      if (ovf_clear)                drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; contents are meaningless until
  // written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a constant vector table, directed
// corner sequences, and random traffic, all checked against a queue model.
module tb_uart_rx_fifo;

  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [4:0] level;
  logic       empty, full, almost_full, overflow;
  logic [7:0] drop_count;
  logic       ovf_clear = 1'b0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .drop_count(drop_count), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered queue of stored bytes plus the sticky state.
  byte unsigned mq[$];
  bit           m_ovf;
  int           m_drop;

  typedef struct {
    bit       rxv;
    bit [7:0] rxd;
    bit       mr;
    bit       clr;
    int       exp_level;
    bit       exp_valid;
    bit [7:0] exp_data;
    bit       exp_ovf;
    int       exp_drop;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("level", 32'(level), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("almost_full", 32'(almost_full), 32'(mq.size() >= AF_LEVEL));
    check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  // One clock: drive inputs, predict the queue's next contents, compare after the edge.
  task automatic cycle(input bit rxv, input bit [7:0] rxd, input bit mr, input bit clr);
    bit do_pop, was_full, do_push, do_drop;
    rx_valid  = rxv;
    rx_data   = rxd;
    m_ready   = mr;
    ovf_clear = clr;
    do_pop   = (mq.size() != 0) && mr;
    was_full = (mq.size() == DEPTH);
    do_push  = rxv && (!was_full || do_pop);
    do_drop  = rxv && was_full && !do_pop;
    @(posedge clk);
    #1;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(rxd);
    if (do_drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    check_model();
  endtask

  task automatic do_reset();
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    m_ready   = 1'b0;
    ovf_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_0_to_f();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      check("af_during_fill", 32'(almost_full), 32'(i + 1 >= AF_LEVEL));
    end
    check("full_after_fill", 32'(full), 32'd1);
  endtask

  initial begin
    // Hand-derived expectations for single push, hold, pop and push-with-pop.
    vecs[0] = '{rxv:1, rxd:8'hA5, mr:0, clr:0, exp_level:1, exp_valid:1, exp_data:8'hA5, exp_ovf:0, exp_drop:0};
    vecs[1] = '{rxv:0, rxd:8'h00, mr:0, clr:0, exp_level:1, exp_valid:1, exp_data:8'hA5, exp_ovf:0, exp_drop:0};
    vecs[2] = '{rxv:0, rxd:8'h00, mr:1, clr:0, exp_level:0, exp_valid:0, exp_data:8'h00, exp_ovf:0, exp_drop:0};
    vecs[3] = '{rxv:1, rxd:8'h3C, mr:0, clr:0, exp_level:1, exp_valid:1, exp_data:8'h3C, exp_ovf:0, exp_drop:0};
    vecs[4] = '{rxv:1, rxd:8'h7E, mr:1, clr:0, exp_level:1, exp_valid:1, exp_data:8'h7E, exp_ovf:0, exp_drop:0};
    vecs[5] = '{rxv:0, rxd:8'h00, mr:1, clr:0, exp_level:0, exp_valid:0, exp_data:8'h00, exp_ovf:0, exp_drop:0};

    do_reset();
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_level", 32'(level), 32'd0);

    for (int v = 0; v < 6; v++) begin
      cycle(vecs[v].rxv, vecs[v].rxd, vecs[v].mr, vecs[v].clr);
      check("vec_level", 32'(level), 32'(vecs[v].exp_level));
      check("vec_valid", 32'(m_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) check("vec_data", 32'(m_data), 32'(vecs[v].exp_data));
      check("vec_ovf", 32'(overflow), 32'(vecs[v].exp_ovf));
      check("vec_drop", 32'(drop_count), 32'(vecs[v].exp_drop));
    end

    // Fill to full, then drain in order.
    do_reset();
    fill_0_to_f();
    check("full_level", 32'(level), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(m_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drained_empty", 32'(empty), 32'd1);

    // Overflow: three drops leave contents intact, then clear.
    fill_0_to_f();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("drop_3", 32'(drop_count), 32'd3);
    check("head_kept", 32'(m_data), 32'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("drop_cleared", 32'(drop_count), 32'd0);

    // Push alongside a pop while full is accepted; 0x55 emerges last.
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    check("full_pushpop_level", 32'(level), 32'd16);
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("last_is_55", 32'(m_data), 32'h55);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Continuous push+pop across pointer wrap.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
      check("stream_level", 32'(level), 32'd1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Clear coincident with a drop, then counter saturation.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hAB, 1'b0, 1'b1);
    check("clr_drop_ovf", 32'(overflow), 32'd1);
    check("clr_drop_cnt", 32'(drop_count), 32'd1);
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'hCC, 1'b0, 1'b0);
    check("drop_saturate", 32'(drop_count), 32'd255);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 3));
    end

    // Mid-operation reset at level 7 with overflow set beforehand.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_reset_level", 32'(level), 32'd7);
    check("pre_reset_ovf", 32'(overflow), 32'd1);
    #2;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    m_ready  = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_valid", 32'(m_valid), 32'd0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    check("async_rst_drop", 32'(drop_count), 32'd0);
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'hBE, 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b0, 1'b0);
    check("post_rst_first", 32'(m_data), 32'hBE);
    check("post_rst_level", 32'(level), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
